// File: rtl/uart_rx_axis_ctrl.sv
// uart_rx_axis_ctrl: turns a UART receive strobe stream into AXI-Stream packets.
// Each received character is held back until the next one arrives, so the byte
// that precedes a stretch of receive silence can be tagged as the end of a packet.
// Packets are also cut every MAX_PKT bytes. Finished bytes go into a
// first-word-fall-through FIFO. Bytes that find the FIFO full are dropped and counted.
module uart_rx_axis_ctrl #(
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int MAX_PKT      = 64,
  parameter int IDLE_TIMEOUT = 4340
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [DATA_BITS-1:0]          rx_data,
  input  logic                          rx_valid,
  output logic [DATA_BITS-1:0]          m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [7:0]                    drop_cnt,
  input  logic                          ovf_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  localparam int PW = $clog2(MAX_PKT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(IDLE_TIMEOUT - 1);
  localparam logic [PW-1:0] PKT_LAST   = PW'(MAX_PKT - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  typedef enum logic [0:0] {EMPTY = 1'b0, HOLD = 1'b1} state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [DATA_BITS-1:0] pend_r;
  logic [TW-1:0]        timer_r;
  logic [PW-1:0]        pkt_cnt_r;
  logic                 accept_s;
  logic                 expire_s;
  logic                 load_s;
  logic                 push_s;
  logic                 push_last_s;
  logic                 pop_s;
  logic                 push_ok_s;
  logic                 drop_s;

  logic [DATA_BITS:0]   mem_r [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_r;
  logic [AW-1:0]        rd_ptr_r;
  logic [LW-1:0]        level_r;

  assign accept_s = rx_valid && en;
  assign expire_s = (state_r == HOLD) && (timer_r == TIMER_LAST);

  // Hold-back FSM: decide when the pending byte is released and how it is tagged.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    push_s      = 1'b0;
    push_last_s = 1'b0;
    case (state_r)
      EMPTY: begin
        if (accept_s) begin
          load_s      = 1'b1;
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      HOLD: begin
        if (accept_s) begin
          // A silence expiring in this same cycle still closes the packet.
          push_s      = 1'b1;
          push_last_s = expire_s ? 1'b1 : (pkt_cnt_r == PKT_LAST);
          load_s      = 1'b1;
          state_nxt_s = HOLD;
        end else if (expire_s) begin
          push_s      = 1'b1;
          push_last_s = 1'b1;
          state_nxt_s = EMPTY;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = EMPTY;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Pending byte, idle timer and per-packet byte count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r    <= '0;
      timer_r   <= '0;
      pkt_cnt_r <= '0;
    end else begin
      if (load_s) begin
        pend_r  <= rx_data;
        timer_r <= '0;
      end else if (state_r == HOLD) begin
        timer_r <= timer_r + TW'(1);
      end
      // The count follows every push attempt, accepted or dropped.
      if (push_s) begin
        pkt_cnt_r <= push_last_s ? '0 : pkt_cnt_r + PW'(1);
      end
    end
  end

  assign pop_s     = (level_r != '0) && m_axis_tready;
  assign push_ok_s = push_s && ((level_r != FULL_LEVEL) || pop_s);
  assign drop_s    = push_s && !push_ok_s;

  // FIFO storage, pointers and occupancy; storage is cleared so the idle head reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= {push_last_s, pend_r};
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      if (push_ok_s && !pop_s) begin
        level_r <= level_r + LW'(1);
      end else if (pop_s && !push_ok_s) begin
        level_r <= level_r - LW'(1);
      end
    end
  end

  // Sticky overflow flag and saturating drop counter; a drop beats a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (drop_s) begin
      overflow <= 1'b1;
      if (ovf_clr) begin
        drop_cnt <= 8'd1;
      end else if (drop_cnt != 8'd255) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end else if (ovf_clr) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end
  end

  assign m_axis_tvalid = (level_r != '0);
  assign m_axis_tdata  = mem_r[rd_ptr_r][DATA_BITS-1:0];
  assign m_axis_tlast  = mem_r[rd_ptr_r][DATA_BITS];
  assign fifo_level    = level_r;

endmodule

// File: tb/tb_uart_rx_axis_ctrl.sv
// Testbench for uart_rx_axis_ctrl: directed scenarios plus random traffic,
// checked every cycle against a timestamp/queue reference model.
module tb_uart_rx_axis_ctrl;

  localparam int DB    = 8;
  localparam int DEPTH = 16;
  localparam int MAXP  = 4;
  localparam int IDLE  = 4340;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic [DB-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [4:0]    fifo_level;
  logic          overflow;
  logic [7:0]    drop_cnt;
  logic          ovf_clr;

  uart_rx_axis_ctrl #(
    .DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .MAX_PKT(MAXP), .IDLE_TIMEOUT(IDLE)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .rx_data(rx_data), .rx_valid(rx_valid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .fifo_level(fifo_level), .overflow(overflow), .drop_cnt(drop_cnt),
    .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct { logic [7:0] d; logic l; } ent_t;
  typedef struct { logic [7:0] d; logic l; int c; } log_t;

  // Reference model: received bytes as timestamps, FIFO as a queue.
  ent_t       mq[$];
  bit         have_pend = 1'b0;
  logic [7:0] pend      = 8'h00;
  int         load_cyc  = 0;
  int         pkt       = 0;
  bit         m_ovf     = 1'b0;
  int         m_drop    = 0;
  int         cyc       = 0;
  log_t       olog[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive inputs, predict the edge, then compare the DUT to the model.
  task automatic step(input logic v, input logic [7:0] d, input logic e,
                      input logic rdy, input logic clr);
    bit   pop, acc, expire, push, plast, push_ok, drop;
    ent_t dummy;
    @(negedge clk);
    rx_valid = v; rx_data = d; en = e; m_axis_tready = rdy; ovf_clr = clr;
    if (m_axis_tvalid && rdy) olog.push_back('{m_axis_tdata, m_axis_tlast, cyc});
    pop     = (mq.size() != 0) && rdy;
    acc     = v && e;
    expire  = have_pend && ((cyc - load_cyc) == IDLE);
    push    = have_pend && (acc || expire);
    plast   = expire || (pkt == MAXP - 1);
    push_ok = push && ((mq.size() < DEPTH) || pop);
    drop    = push && !push_ok;
    @(posedge clk);
    if (pop) dummy = mq.pop_front();
    if (push_ok) mq.push_back('{pend, plast});
    if (push) pkt = plast ? 0 : pkt + 1;
    if (drop) begin
      m_ovf  = 1'b1;
      m_drop = clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
    end else if (clr) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    if (acc) begin
      have_pend = 1'b1; pend = d; load_cyc = cyc;
    end else if (expire) begin
      have_pend = 1'b0;
    end
    cyc++;
    #1;
    check_eq("tvalid", m_axis_tvalid, mq.size() != 0);
    check_eq("level", fifo_level, mq.size());
    if (mq.size() != 0) begin
      check_eq("tdata", m_axis_tdata, mq[0].d);
      check_eq("tlast", m_axis_tlast, mq[0].l);
    end
    check_eq("overflow", overflow, m_ovf);
    check_eq("drop_cnt", drop_cnt, m_drop);
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) step(1'b0, 8'h00, 1'b1, rdy, 1'b0);
  endtask

  task automatic model_clear();
    mq.delete();
    have_pend = 1'b0; pkt = 0; m_ovf = 1'b0; m_drop = 0;
  endtask

  int s33;
  int base;

  initial begin
    rst = 1'b1; en = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    m_axis_tready = 1'b0; ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tvalid", m_axis_tvalid, 1'b0);
    check_eq("rst_tlast", m_axis_tlast, 1'b0);
    check_eq("rst_tdata", m_axis_tdata, 8'h00);
    check_eq("rst_level", fifo_level, 5'd0);
    check_eq("rst_overflow", overflow, 1'b0);
    check_eq("rst_drop_cnt", drop_cnt, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();

    // Three bytes 100 clocks apart; the last one closes the packet on silence.
    olog.delete();
    step(1'b1, 8'h11, 1'b1, 1'b1, 1'b0);
    idle(99, 1'b1);
    step(1'b1, 8'h22, 1'b1, 1'b1, 1'b0);
    idle(99, 1'b1);
    s33 = cyc;
    step(1'b1, 8'h33, 1'b1, 1'b1, 1'b0);
    idle(IDLE + 5, 1'b1);
    check_eq("seq3_count", olog.size(), 3);
    if (olog.size() == 3) begin
      check_eq("seq3_b0", {olog[0].l, olog[0].d}, 9'h011);
      check_eq("seq3_b1", {olog[1].l, olog[1].d}, 9'h022);
      check_eq("seq3_b2", {olog[2].l, olog[2].d}, 9'h133);
      check_eq("seq3_latency", olog[2].c - s33, IDLE + 1);
    end

    // Six back-to-back bytes with a 4-byte packet limit.
    olog.delete();
    for (int i = 1; i <= 6; i++) step(1'b1, 8'(i), 1'b1, 1'b1, 1'b0);
    idle(IDLE + 5, 1'b1);
    check_eq("maxpkt_count", olog.size(), 6);
    for (int i = 0; i < olog.size(); i++) begin
      check_eq("maxpkt_data", olog[i].d, i + 1);
      check_eq("maxpkt_last", olog[i].l, (i == 3) || (i == 5));
    end

    // Stalled sink: 20 bytes into a 16-deep FIFO.
    olog.delete();
    for (int i = 1; i <= 20; i++) step(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
    idle(IDLE + 5, 1'b0);
    check_eq("full_level", fifo_level, 5'd16);
    check_eq("full_overflow", overflow, 1'b1);
    check_eq("full_drop_cnt", drop_cnt, 8'd4);
    // Full FIFO with simultaneous pop and push: accepted, no drop.
    step(1'b1, 8'hA1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'hA2, 1'b1, 1'b1, 1'b0);
    check_eq("pp_level", fifo_level, 5'd16);
    check_eq("pp_drop_cnt", drop_cnt, 8'd4);
    // Clear coinciding with a drop: the drop wins.
    step(1'b1, 8'hA3, 1'b1, 1'b0, 1'b1);
    check_eq("clr_drop_overflow", overflow, 1'b1);
    check_eq("clr_drop_cnt", drop_cnt, 8'd1);
    idle(20, 1'b1);
    check_eq("drain_count", olog.size(), 17);
    for (int i = 0; i < olog.size(); i++) begin
      check_eq("drain_data", olog[i].d, (i < 16) ? i + 1 : 8'hA1);
    end

    // Reset while holding a byte with 5 bytes queued.
    for (int i = 0; i < 5; i++) step(1'b1, 8'hC0 + 8'(i), 1'b1, 1'b0, 1'b0);
    check_eq("pre_rst_level", fifo_level, 5'd5);
    @(negedge clk);
    rx_valid = 1'b0; ovf_clr = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_tvalid", m_axis_tvalid, 1'b0);
    check_eq("midrst_level", fifo_level, 5'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    olog.delete();
    idle(IDLE + 10, 1'b1);
    check_eq("post_rst_no_output", olog.size(), 0);

    // Random traffic, light back-pressure.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 9) != 0,
           $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
    end
    idle(IDLE + 5, 1'($urandom_range(0, 1)));
    // Random traffic, heavy back-pressure to exercise drops and clears.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1) == 0, 8'($urandom), $urandom_range(0, 9) != 0,
           $urandom_range(0, 9) < 2, $urandom_range(0, 29) == 0);
    end
    base = olog.size();
    idle(IDLE + 30, 1'b1);
    check_eq("final_empty", fifo_level, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
